// File: rtl/ndn_hash_pkg.sv
// rtl/ndn_hash_pkg.sv - shared widths and enums for the NDN name-hash bucket table
package ndn_hash_pkg;

    localparam int KEY_W  = 64;
    localparam int IDX_W  = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << IDX_W;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_HIT     = 2'd0,
        ST_MISS    = 2'd1,
        ST_DONE    = 2'd2,
        ST_COLLIDE = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CMP  = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/hash_table_ram.sv
// rtl/hash_table_ram.sv - single-port bucket storage, synchronous read with 1-cycle latency
module hash_table_ram #(
    parameter int AW = 10,
    parameter int DW = 80
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    // Read-before-write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hash_bucket_table.sv
// rtl/hash_bucket_table.sv - direct-mapped exact-match table with LOOKUP/INSERT/DELETE
module hash_bucket_table
    import ndn_hash_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [KEY_W-1:0]    req_key,
    input  logic [IDX_W-1:0]    req_hash,
    input  logic [DATA_W-1:0]   req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [IDX_W:0]      occupancy
);

    localparam logic [IDX_W:0] OCC_MAX = (IDX_W+1)'(DEPTH);

    state_e              state;
    op_e                 op_q;
    logic [KEY_W-1:0]    key_q;
    logic [IDX_W-1:0]    hash_q;
    logic [DATA_W-1:0]   data_q;
    logic [DEPTH-1:0]    valid_bits;

    logic                    ram_we;
    logic [KEY_W+DATA_W-1:0] ram_rdata;
    logic [KEY_W-1:0]        ram_key;
    logic [DATA_W-1:0]       ram_pay;

    logic                match;
    logic                set_valid;
    logic                clr_valid;
    status_e             nxt_status;
    logic [DATA_W-1:0]   nxt_data;

    hash_table_ram #(
        .AW (IDX_W),
        .DW (KEY_W + DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (hash_q),
        .wdata ({key_q, data_q}),
        .rdata (ram_rdata)
    );

    assign ram_key   = ram_rdata[KEY_W+DATA_W-1:DATA_W];
    assign ram_pay   = ram_rdata[DATA_W-1:0];
    assign match     = valid_bits[hash_q] && (ram_key == key_q);
    assign req_ready = (state == S_IDLE) && !rst;

    // Outcome of the compare stage; only acts while in CMP so writes cannot leak elsewhere.
    always_comb begin
        ram_we     = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        nxt_status = ST_MISS;
        nxt_data   = '0;
        if (state == S_CMP) begin
            case (op_q)
                OP_LOOKUP: begin
                    if (match) begin
                        nxt_status = ST_HIT;
                        nxt_data   = ram_pay;
                    end
                end
                OP_INSERT: begin
                    if (!valid_bits[hash_q]) begin
                        ram_we     = 1'b1;
                        set_valid  = 1'b1;
                        nxt_status = ST_DONE;
                    end else if (match) begin
                        ram_we     = 1'b1;
                        nxt_status = ST_DONE;
                        nxt_data   = ram_pay;
                    end else begin
                        nxt_status = ST_COLLIDE;
                        nxt_data   = ram_pay;
                    end
                end
                OP_DELETE: begin
                    if (match) begin
                        clr_valid  = 1'b1;
                        nxt_status = ST_DONE;
                        nxt_data   = ram_pay;
                    end
                end
                default: begin
                    nxt_status = ST_MISS;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_LOOKUP;
            key_q      <= '0;
            hash_q     <= '0;
            data_q     <= '0;
            valid_bits <= '0;
            occupancy  <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'd0;
            rsp_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= op_e'(req_op);
                        key_q  <= req_key;
                        hash_q <= req_hash;
                        data_q <= req_data;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (set_valid) begin
                        valid_bits[hash_q] <= 1'b1;
                        if (occupancy != OCC_MAX) begin
                            occupancy <= occupancy + 1'b1;
                        end
                    end
                    if (clr_valid) begin
                        valid_bits[hash_q] <= 1'b0;
                        if (occupancy != '0) begin
                            occupancy <= occupancy - 1'b1;
                        end
                    end
                    rsp_status <= nxt_status;
                    rsp_data   <= nxt_data;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_bucket_table.sv
// tb/tb_hash_bucket_table.sv - randomized self-checking bench with behavioural table model
module tb_hash_bucket_table;

    localparam int HIT = 0, MISS = 1, DONE = 2, COLLIDE = 3;
    localparam int LOOKUP = 0, INSERT = 1, DELETE = 2, RSVD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_key;
    logic [9:0]  req_hash;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_data;
    logic [10:0] occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_valid [1024];
    logic [63:0] m_key   [1024];
    logic [15:0] m_data  [1024];
    int          m_occ;

    hash_bucket_table dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .req_hash   (req_hash),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
        m_occ = 0;
    endtask

    task automatic model_op(input int op, input logic [63:0] key, input int h,
                            input logic [15:0] d, output int st, output logic [15:0] rd);
        logic hit;
        hit = m_valid[h] && (m_key[h] == key);
        st  = MISS;
        rd  = 16'h0;
        case (op)
            LOOKUP: if (hit) begin st = HIT; rd = m_data[h]; end
            INSERT: begin
                if (!m_valid[h]) begin
                    m_valid[h] = 1'b1; m_key[h] = key; m_data[h] = d; m_occ++; st = DONE;
                end else if (hit) begin
                    rd = m_data[h]; m_data[h] = d; st = DONE;
                end else begin
                    rd = m_data[h]; st = COLLIDE;
                end
            end
            DELETE: if (hit) begin
                rd = m_data[h]; m_valid[h] = 1'b0; m_occ--; st = DONE;
            end
            default: ;
        endcase
    endtask

    // Caller is just past a negedge with the DUT idle or about to be.
    task automatic run_op(input int op, input logic [63:0] key, input int h,
                          input logic [15:0] d, input int hold);
        int st, n, lat;
        logic [15:0] rd;
        logic [1:0]  s0;
        logic [15:0] d0;
        model_op(op, key, h, d, st, rd);
        req_valid = 1'b1; req_op = 2'(op); req_key = key; req_hash = 10'(h); req_data = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_op = 2'($urandom); req_key = {$urandom, $urandom}; req_hash = 10'($urandom);
        req_data = 16'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        chk("latency", 64'(lat), 64'd3);
        chk("status", 64'(rsp_status), 64'(st));
        chk("rsp_data", 64'(rsp_data), 64'(rd));
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("busy_ready", {63'd0, req_ready}, 64'd0);
        s0 = rsp_status; d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_status", 64'(rsp_status), 64'(s0));
            chk("hold_data", 64'(rsp_data), 64'(d0));
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("idle_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_key = '0; req_hash = '0;
        req_data = '0; rsp_ready = 1'b0;
        model_clear();
        for (int i = 0; i < 1024; i++) begin m_key[i] = '0; m_data[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_status", 64'(rsp_status), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

        run_op(LOOKUP, 64'h1234, 5, 16'h0000, 0);
        run_op(INSERT, 64'h1234, 5, 16'h00A7, 0);
        chk("occ_one", 64'(occupancy), 64'd1);
        run_op(LOOKUP, 64'h1234, 5, 16'h0000, 0);
        run_op(INSERT, 64'h9999, 5, 16'h0003, 0);
        run_op(LOOKUP, 64'h1234, 5, 16'h0000, 0);
        run_op(INSERT, 64'h1234, 5, 16'h0042, 0);
        run_op(DELETE, 64'h1234, 5, 16'h0000, 0);
        run_op(DELETE, 64'h1234, 5, 16'h0000, 0);
        run_op(RSVD, 64'h1234, 5, 16'h0000, 0);
        chk("occ_zero", 64'(occupancy), 64'd0);
        // Garbage requests while RESP is held must not be taken.
        run_op(LOOKUP, 64'h1234, 5, 16'h0000, 5);
        chk("occ_after_hold", 64'(occupancy), 64'(m_occ));

        for (int i = 0; i < 1024; i++)
            run_op(INSERT, 64'hF000_0000_0000_0000 | 64'(i), i, 16'(i) ^ 16'h5A5A, 0);
        chk("occ_full", 64'(occupancy), 64'd1024);
        run_op(INSERT, 64'h7777, 300, 16'h1111, 0);
        chk("occ_full_collide", 64'(occupancy), 64'd1024);

        // Reset while the op sits in CMP.
        req_valid = 1'b1; req_op = 2'(INSERT); req_key = 64'h5555; req_hash = 10'd0;
        req_data = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", {63'd0, req_ready}, 64'd1);
        model_clear();
        run_op(LOOKUP, m_key[0], 0, 16'h0, 0);
        run_op(LOOKUP, m_key[5], 5, 16'h0, 0);
        run_op(LOOKUP, m_key[1023], 1023, 16'h0, 0);
        chk("occ_after_rst", 64'(occupancy), 64'd0);

        for (int i = 0; i < 400; i++)
            run_op(int'($urandom_range(0, 3)), 64'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 2)));
        chk("occ_final", 64'(occupancy), 64'(m_occ));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
